// File: rtl/dsp_div_pkg.sv
// Shared definitions for the iterative 36/18 unsigned divider.
//   state_t            : divider FSM states (IDLE, RUN, DONE)
//   DIVIDEND_WIDTH_DEF : default dividend / quotient width (also iteration count)
//   DIVISOR_WIDTH_DEF  : default divisor / remainder width
//   CNT_WIDTH          : step counter width for the default dividend width
package dsp_div_pkg;

    localparam int unsigned DIVIDEND_WIDTH_DEF = 36;
    localparam int unsigned DIVISOR_WIDTH_DEF  = 18;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CNT_WIDTH = cnt_width(DIVIDEND_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dsp_div_step.sv
// One combinational restoring-division step.
//   rem_in  : current partial remainder (DIVISOR_WIDTH+1 bits, always < divisor)
//   bit_in  : next dividend bit shifted into the remainder
//   divisor : unsigned divisor
//   rem_out : partial remainder after shift and trial subtract/restore
//   q_bit   : quotient bit produced by this step
module dsp_div_step #(
    parameter int unsigned DIVISOR_WIDTH = 18
) (
    input  logic [DIVISOR_WIDTH:0]   rem_in,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH:0]   rem_out,
    output logic                     q_bit
);

    logic [DIVISOR_WIDTH+1:0] shifted;
    logic [DIVISOR_WIDTH:0]   diff;
    logic                     ge;

    always_comb begin
        shifted = {rem_in, bit_in};
        ge      = (shifted >= {2'b00, divisor});
        // When ge holds the difference is < divisor, so the truncated
        // subtraction is exact.
        diff    = shifted[DIVISOR_WIDTH:0] - {1'b0, divisor};
        rem_out = ge ? diff : shifted[DIVISOR_WIDTH:0];
        q_bit   = ge;
    end

endmodule

// File: rtl/dsp_div_36by18u.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per clock.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   dividend, divisor     : unsigned operands
//   out_valid / out_ready : result handshake (result held while stalled)
//   quotient, remainder   : floor(dividend/divisor), dividend mod divisor
//   div_by_zero           : divisor was 0 (quotient all ones, remainder 0)
module dsp_div_36by18u
    import dsp_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
    parameter int unsigned DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int unsigned CW = cnt_width(DIVIDEND_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIVIDEND_WIDTH - 1);

    state_t                     state;
    logic [CW-1:0]              cnt;
    // The quotient register doubles as the dividend shift register: dividend
    // bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVIDEND_WIDTH-1:0]  q_reg;
    logic [DIVISOR_WIDTH:0]     rem_reg;
    logic [DIVISOR_WIDTH-1:0]   dsor_reg;
    logic [DIVISOR_WIDTH:0]     rem_next;
    logic                       q_bit;

    dsp_div_step #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_step (
        .rem_in  (rem_reg),
        .bit_in  (q_reg[DIVIDEND_WIDTH-1]),
        .divisor (dsor_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign in_ready  = rst_n && (state == IDLE);
    assign quotient  = q_reg;
    assign remainder = rem_reg[DIVISOR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            dsor_reg    <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            q_reg       <= '1;
                            rem_reg     <= '0;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_reg       <= dividend;
                            rem_reg     <= '0;
                            dsor_reg    <= divisor;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    q_reg   <= {q_reg[DIVIDEND_WIDTH-2:0], q_bit};
                    rem_reg <= rem_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
